// File: rtl/uart_sample_bridge.sv
// uart_sample_bridge
//
// Sits between the UART core's Rx/Tx FIFOs and the filter datapath.
//   Rx path: pops bytes from a first-word-fall-through Rx FIFO, pairs them into little-endian
//            2*DBITS samples and offers each one on a valid/ready handshake.
//   Tx path: accepts filtered samples on a valid/ready handshake and pushes the low byte, then
//            the high byte, into the Tx FIFO, respecting tx_full.
// The two paths are independent and may both be busy in the same cycle.
//
// Optional feature (macro UART_BRIDGE_TIMEOUT_EN):
//   When defined, a partial sample whose high byte does not arrive within TIMEOUT_CYCLES is
//   dropped and timeout_err pulses for one cycle. When undefined, no counter exists,
//   timeout_err is tied low and the bridge waits forever for the high byte.
//
// Parameters:
//   DBITS          UART word width; sample width is 2*DBITS.
//   TIMEOUT_CYCLES cycles allowed between low and high byte (minimum 2).
//   TO_BITS        timeout counter width, 2^TO_BITS > TIMEOUT_CYCLES.
//
// Ports:
//   clk_100MHz     in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   rx_empty       in   Rx FIFO empty
//   rx_data        in   Rx FIFO head word
//   rx_read        out  Rx FIFO pop strobe (combinational)
//   tx_full        in   Tx FIFO full
//   tx_write       out  Tx FIFO push strobe (combinational)
//   tx_data        out  byte presented to the Tx FIFO (combinational)
//   smp_out_data   out  assembled sample (registered)
//   smp_out_valid  out  smp_out_data valid (registered)
//   smp_out_ready  in   filter accepts the sample
//   smp_in_data    in   filtered sample
//   smp_in_valid   in   smp_in_data valid
//   smp_in_ready   out  bridge accepts a sample (combinational)
//   timeout_err    out  one-cycle pulse when a partial sample is discarded (registered)

module uart_sample_bridge #(
   parameter int unsigned DBITS          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned TO_BITS        = 20
) (
   input  logic               clk_100MHz,
   input  logic               reset_n,
   // Rx FIFO side
   input  logic               rx_empty,
   input  logic [DBITS-1:0]   rx_data,
   output logic               rx_read,
   // Tx FIFO side
   input  logic               tx_full,
   output logic               tx_write,
   output logic [DBITS-1:0]   tx_data,
   // Sample stream to the filter
   output logic [2*DBITS-1:0] smp_out_data,
   output logic               smp_out_valid,
   input  logic               smp_out_ready,
   // Sample stream from the filter
   input  logic [2*DBITS-1:0] smp_in_data,
   input  logic               smp_in_valid,
   output logic               smp_in_ready,
   // Status
   output logic               timeout_err
);

   localparam int unsigned SW = 2 * DBITS;

   // Elaboration-time parameter sanity checks.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_sample_bridge: TIMEOUT_CYCLES must be at least 2");
   end
   if ((TIMEOUT_CYCLES >> TO_BITS) != 32'd0) begin : g_bad_to_bits
      $error("uart_sample_bridge: TO_BITS too narrow for TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {
      RxLo,
      RxHi,
      RxOut
   } rx_state_e;

   typedef enum logic [1:0] {
      TxIdle,
      TxLo,
      TxHi
   } tx_state_e;

   // ---------------------------------------------------------------------------------------------
   // Receive path
   // ---------------------------------------------------------------------------------------------
   rx_state_e          rx_state_q, rx_state_d;
   logic [DBITS-1:0]   lo_q, lo_d;
   logic [SW-1:0]      smp_data_q, smp_data_d;
   logic               smp_valid_q, smp_valid_d;

`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam logic [TO_BITS-1:0] ToLast = TO_BITS'(TIMEOUT_CYCLES - 1);

   logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
   logic               to_err_q, to_err_d;
`endif

   always_comb begin
      rx_state_d  = rx_state_q;
      lo_d        = lo_q;
      smp_data_d  = smp_data_q;
      smp_valid_d = smp_valid_q;
      rx_read     = 1'b0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
      to_err_d    = 1'b0;
`endif

      unique case (rx_state_q)
         RxLo: begin
            rx_read = ~rx_empty;
            if (!rx_empty) begin
               lo_d       = rx_data;
               rx_state_d = RxHi;
`ifdef UART_BRIDGE_TIMEOUT_EN
               to_cnt_d   = '0;
`endif
            end
         end

         RxHi: begin
            rx_read = ~rx_empty;
            // A pop always wins over an expiry in the same cycle.
            if (!rx_empty) begin
               smp_data_d  = {rx_data, lo_q};
               smp_valid_d = 1'b1;
               rx_state_d  = RxOut;
            end
`ifdef UART_BRIDGE_TIMEOUT_EN
            else if (to_cnt_q == ToLast) begin
               to_err_d   = 1'b1;
               rx_state_d = RxLo;
            end else if (to_cnt_q != '1) begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end

         RxOut: begin
            // No pops here: holding the sample is what backpressures the Rx FIFO.
            if (smp_out_ready) begin
               smp_valid_d = 1'b0;
               rx_state_d  = RxLo;
            end
         end

         default: begin
            rx_state_d  = RxLo;
            smp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         rx_state_q  <= RxLo;
         lo_q        <= '0;
         smp_data_q  <= '0;
         smp_valid_q <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         lo_q        <= lo_d;
         smp_data_q  <= smp_data_d;
         smp_valid_q <= smp_valid_d;
      end
   end

`ifdef UART_BRIDGE_TIMEOUT_EN
   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt_q <= '0;
         to_err_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_d;
         to_err_q <= to_err_d;
      end
   end

   assign timeout_err = to_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign smp_out_data  = smp_data_q;
   assign smp_out_valid = smp_valid_q;

   // ---------------------------------------------------------------------------------------------
   // Transmit path
   // ---------------------------------------------------------------------------------------------
   tx_state_e     tx_state_q, tx_state_d;
   logic [SW-1:0] tx_hold_q, tx_hold_d;

   always_comb begin
      tx_state_d   = tx_state_q;
      tx_hold_d    = tx_hold_q;
      tx_write     = 1'b0;
      smp_in_ready = 1'b0;
      tx_data      = tx_hold_q[DBITS-1:0];

      unique case (tx_state_q)
         TxIdle: begin
            smp_in_ready = 1'b1;
            if (smp_in_valid) begin
               tx_hold_d  = smp_in_data;
               tx_state_d = TxLo;
            end
         end

         TxLo: begin
            tx_write = ~tx_full;
            if (!tx_full) begin
               tx_state_d = TxHi;
            end
         end

         TxHi: begin
            tx_data  = tx_hold_q[SW-1:DBITS];
            tx_write = ~tx_full;
            if (!tx_full) begin
               tx_state_d = TxIdle;
            end
         end

         default: begin
            tx_state_d = TxIdle;
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TxIdle;
         tx_hold_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_hold_q  <= tx_hold_d;
      end
   end

endmodule

// File: tb/tb_uart_sample_bridge.sv
// Testbench for uart_sample_bridge: directed stimulus with a queue-based scoreboard.
// The stimulus process pushes expected samples/bytes and direct observations into queues;
// a single monitor process (on the rising edge) models the Rx FIFO and does every comparison.

module tb_uart_sample_bridge;

   localparam int unsigned DBITS = 8;
   localparam int unsigned TO    = 100;
   localparam int unsigned TOB   = 20;
`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int unsigned EXP_ERR = 1;
`else
   localparam int unsigned EXP_ERR = 0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              rx_empty;
   logic [DBITS-1:0]  rx_data;
   logic              rx_read;
   logic              tx_full;
   logic              tx_write;
   logic [DBITS-1:0]  tx_data;
   logic [15:0]       smp_out_data;
   logic              smp_out_valid;
   logic              smp_out_ready;
   logic [15:0]       smp_in_data;
   logic              smp_in_valid;
   logic              smp_in_ready;
   logic              timeout_err;

   always #5 clk = ~clk;

   uart_sample_bridge #(
      .DBITS          (DBITS),
      .TIMEOUT_CYCLES (TO),
      .TO_BITS        (TOB)
   ) dut (
      .clk_100MHz    (clk),
      .reset_n       (reset_n),
      .rx_empty      (rx_empty),
      .rx_data       (rx_data),
      .rx_read       (rx_read),
      .tx_full       (tx_full),
      .tx_write      (tx_write),
      .tx_data       (tx_data),
      .smp_out_data  (smp_out_data),
      .smp_out_valid (smp_out_valid),
      .smp_out_ready (smp_out_ready),
      .smp_in_data   (smp_in_data),
      .smp_in_valid  (smp_in_valid),
      .smp_in_ready  (smp_in_ready),
      .timeout_err   (timeout_err)
   );

   // Scoreboard queues
   logic [7:0]  rx_fifo[$];
   logic [15:0] exp_smp[$];
   logic [7:0]  exp_tx[$];
   string       chk_name[$];
   logic [31:0] chk_act[$];
   logic [31:0] chk_exp[$];

   int checks   = 0;
   int failures = 0;

   // Monitor-owned observations (edge indices count rising edges from 0)
   int   cyc       = 0;
   int   last_pop  = -1000;
   int   n_pops    = 0;
   int   n_err     = 0;
   int   n_txw     = 0;
   int   last_txw  = -1;
   int   tx_accept = -1;
   int   last_acc  = -1000;
   int   rise_gap  = -1;
   logic prev_valid = 1'b0;
   logic pop_now;

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor + Rx FIFO model
   initial begin
      rx_empty = 1'b1;
      rx_data  = '0;
      forever begin
         @(posedge clk);
         while (chk_name.size() > 0) begin
            compare(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
         end
         if (smp_out_valid) begin
            if (!prev_valid) begin
               compare("smp_latency", 32'(cyc - last_pop), 32'd1);
               rise_gap = cyc - last_acc;
            end
            if (exp_smp.size() == 0) begin
               compare("smp_unexpected", 32'(exp_smp.size()), 32'd1);
            end else begin
               compare("smp_data", {16'h0, smp_out_data}, {16'h0, exp_smp[0]});
               if (smp_out_ready) begin
                  void'(exp_smp.pop_front());
                  last_acc = cyc;
               end
            end
         end
         if (tx_write) begin
            compare("tx_write_while_full", {31'h0, tx_full}, 32'd0);
            if (exp_tx.size() == 0) begin
               compare("tx_unexpected", 32'(exp_tx.size()), 32'd1);
            end else begin
               compare("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
            n_txw++;
            last_txw = cyc;
         end
         if (smp_in_valid && smp_in_ready && reset_n) tx_accept = cyc;
         if (timeout_err) begin
            n_err++;
            compare("timeout_latency", 32'(cyc - last_pop), 32'(TO + 1));
         end
         pop_now = rx_read && reset_n;
         if (pop_now) begin
            last_pop = cyc;
            n_pops++;
         end
         prev_valid = smp_out_valid;
         cyc++;
         #1;
         if (pop_now && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
         rx_empty = (rx_fifo.size() == 0);
         rx_data  = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
      end
   end

   task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_name.push_back(name);
      chk_act.push_back(act);
      chk_exp.push_back(exp);
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_fifo.push_back(b);
   endtask

   task automatic wait_drain(input int maxc);
      int k = 0;
      while ((exp_smp.size() > 0 || exp_tx.size() > 0) && k < maxc) begin
         @(negedge clk);
         k++;
      end
      if (exp_smp.size() > 0 || exp_tx.size() > 0) begin
         expect_eq("drain_timeout", 32'(exp_smp.size() + exp_tx.size()), 32'd0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      expect_eq({tag, "_smp_out_valid"}, {31'h0, smp_out_valid}, 32'd0);
      expect_eq({tag, "_smp_out_data"}, {16'h0, smp_out_data}, 32'd0);
      expect_eq({tag, "_timeout_err"}, {31'h0, timeout_err}, 32'd0);
      expect_eq({tag, "_smp_in_ready"}, {31'h0, smp_in_ready}, 32'd1);
      expect_eq({tag, "_rx_read"}, {31'h0, rx_read}, 32'd0);
      expect_eq({tag, "_tx_write"}, {31'h0, tx_write}, 32'd0);
      expect_eq({tag, "_tx_data"}, {24'h0, tx_data}, 32'd0);
   endtask

   initial begin
      int n0;
      int e0;
      int exp_edge;
      reset_n       = 1'b0;
      smp_out_ready = 1'b0;
      smp_in_valid  = 1'b0;
      smp_in_data   = '0;
      tx_full       = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: one sample, ready high
      smp_out_ready = 1'b1;
      n0 = n_pops;
      exp_smp.push_back(16'h1234);
      push_byte(8'h34);
      push_byte(8'h12);
      wait_drain(50);
      expect_eq("t1_pops", 32'(n_pops - n0), 32'd2);

      // 2: backpressure with four bytes queued
      smp_out_ready = 1'b0;
      n0 = n_pops;
      exp_smp.push_back(16'h1234);
      exp_smp.push_back(16'h5678);
      push_byte(8'h34);
      push_byte(8'h12);
      push_byte(8'h78);
      push_byte(8'h56);
      repeat (10) @(negedge clk);
      expect_eq("t2_pops_stalled", 32'(n_pops - n0), 32'd2);
      expect_eq("t2_valid_held", {31'h0, smp_out_valid}, 32'd1);
      expect_eq("t2_data_held", {16'h0, smp_out_data}, 32'h1234);
      smp_out_ready = 1'b1;
      wait_drain(50);
      expect_eq("t2_pops_total", 32'(n_pops - n0), 32'd4);
      expect_eq("t2_rearm_gap", 32'(rise_gap), 32'd3);

      // 3: Tx split with tx_full backpressure
      n0 = n_txw;
      exp_tx.push_back(8'hEF);
      exp_tx.push_back(8'hBE);
      smp_in_data  = 16'hBEEF;
      smp_in_valid = 1'b1;
      expect_eq("t3_in_ready_idle", {31'h0, smp_in_ready}, 32'd1);
      @(negedge clk);
      smp_in_valid = 1'b0;
      expect_eq("t3_in_ready_busy", {31'h0, smp_in_ready}, 32'd0);
      expect_eq("t3_write_lo", {31'h0, tx_write}, 32'd1);
      @(negedge clk);
      expect_eq("t3_first_write_edge", 32'(last_txw), 32'(tx_accept + 1));
      tx_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         expect_eq("t3_no_write_full", {31'h0, tx_write}, 32'd0);
      end
      tx_full  = 1'b0;
      exp_edge = cyc;
      @(negedge clk);
      expect_eq("t3_second_write_edge", 32'(last_txw), 32'(exp_edge));
      expect_eq("t3_in_ready_back", {31'h0, smp_in_ready}, 32'd1);
      expect_eq("t3_writes", 32'(n_txw - n0), 32'd2);
      wait_drain(20);

`ifdef UART_BRIDGE_TIMEOUT_EN
      // 4: partial sample times out, next pair assembles cleanly
      e0 = n_err;
      push_byte(8'hAA);
      repeat (130) @(negedge clk);
      expect_eq("t4_err_pulses", 32'(n_err - e0), 32'd1);
      exp_smp.push_back(16'h0201);
      push_byte(8'h01);
      push_byte(8'h02);
      wait_drain(50);
`else
      // 6: no timeout logic, high byte arrives much later
      e0 = n_err;
      push_byte(8'h11);
      repeat (2000) @(negedge clk);
      expect_eq("t6_no_err", 32'(n_err - e0), 32'd0);
      exp_smp.push_back(16'h2211);
      push_byte(8'h22);
      wait_drain(50);
`endif

      // 5: reset with a low byte pending
      n0 = n_pops;
      push_byte(8'h55);
      repeat (4) @(negedge clk);
      expect_eq("t5_low_popped", 32'(n_pops - n0), 32'd1);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("t5");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      exp_smp.push_back(16'h2010);
      push_byte(8'h10);
      push_byte(8'h20);
      wait_drain(50);

      expect_eq("timeout_err_count", 32'(n_err), 32'(EXP_ERR));
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
